// File: rtl/debug_pll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debug_pll_pkg
// Brief    : Shared types, 50 MHz refclk defaults and timer sizing helper for
//            the debug PLL reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package debug_pll_pkg;

  // Sequencer states; encodings are visible on the debug state port.
  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  // Defaults for a 50 MHz board reference clock.
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 50000;   // 1 ms
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_CNT_W          = 8;

  // The shared timer only ever counts up to (largest cycle parameter - 1).
  function automatic int timer_width(input int pll_rst_cycles,
                                     input int lock_timeout,
                                     input int stable_cycles);
    int m;
    m = pll_rst_cycles;
    if (lock_timeout > m)  m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_pll_lock_sync.sv
`default_nettype none
// ============================================================================
// Module   : debug_pll_lock_sync
// Brief    : SYNC_STAGES-flop synchronizer for a single asynchronous status
//            bit, asynchronously reset to 0. Generic; reused for other bits.
// Revision : 1.0 - initial release
// ============================================================================
module debug_pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the asynchronous bit through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/debug_pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : debug_pll_rst_seq
// Brief    : Reset sequencer and lock monitor for the 250 MHz debug PLL.
//            Pulses the PLL reset, waits for a debounced lock, then releases
//            the system reset; counts lock losses and lock timeouts.
// Config   : DEBUG_PLL_RST_SEQ_RELOCK_EN - when defined, a lock loss in RUN
//            forces a full PLL reset; otherwise the PLL relocks on its own.
// Revision : 1.0 - initial release
// ============================================================================
module debug_pll_rst_seq
  import debug_pll_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             sw_reset,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [1:0]       state_o
);

  localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TW-1:0] c_pll_last = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] c_tmo_last = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] c_stb_last = TW'(STABLE_CYCLES - 1);

`ifdef DEBUG_PLL_RST_SEQ_RELOCK_EN
  localparam seq_state_t c_loss_state = PLL_RST;
`else
  localparam seq_state_t c_loss_state = WAIT_LOCK;
`endif

  seq_state_t       r_state, w_next_state;
  logic [TW-1:0]    r_timer, w_next_timer;
  logic [CNT_W-1:0] r_loss, r_tmo;
  logic             r_pll_rst, r_sys_rst, r_ready;
  logic             w_lock_s, w_inc_loss, w_inc_tmo;

  debug_pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk     (refclk),
    .rst     (rst),
    .i_async (locked),
    .o_sync  (w_lock_s)
  );

  // Next-state, timer and counter-increment decisions.
  always_comb begin
    w_next_state = r_state;
    w_inc_loss   = 1'b0;
    w_inc_tmo    = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_timer == c_pll_last) w_next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (w_lock_s) begin
          w_next_state = STABLE;
        end else if (r_timer == c_tmo_last) begin
          w_next_state = PLL_RST;
          w_inc_tmo    = 1'b1;
        end
      end
      STABLE: begin
        if (!w_lock_s)                 w_next_state = WAIT_LOCK;
        else if (r_timer == c_stb_last) w_next_state = RUN;
      end
      RUN: begin
        if (!w_lock_s) begin
          w_next_state = c_loss_state;
          w_inc_loss   = 1'b1;
        end
      end
      default: w_next_state = PLL_RST;
    endcase
    // Software restart wins everywhere but never hides a genuine lock loss.
    if (sw_reset) begin
      w_next_state = PLL_RST;
      w_inc_tmo    = 1'b0;
    end
    if ((w_next_state != r_state) || sw_reset || (r_state == RUN))
      w_next_timer = '0;
    else
      w_next_timer = r_timer + 1'b1;
  end

  // State, timer and registered output decode.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state   <= PLL_RST;
      r_timer   <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_timer   <= w_next_timer;
      r_pll_rst <= (w_next_state == PLL_RST);
      r_sys_rst <= (w_next_state != RUN);
      r_ready   <= (w_next_state == RUN);
    end
  end

  // Saturating lock-health counters, cleared only by rst.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_loss <= '0;
      r_tmo  <= '0;
    end else begin
      if (w_inc_loss && (r_loss != '1)) r_loss <= r_loss + 1'b1;
      if (w_inc_tmo  && (r_tmo  != '1)) r_tmo  <= r_tmo + 1'b1;
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst       = r_sys_rst;
  assign ready         = r_ready;
  assign loss_count    = r_loss;
  assign timeout_count = r_tmo;
  assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_debug_pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_pll_rst_seq
// Brief    : Scoreboard bench for debug_pll_rst_seq. A rule-level reference
//            model predicts every output change and the cycle it happens in;
//            a monitor compares each observed change against that queue.
// Config   : honours DEBUG_PLL_RST_SEQ_RELOCK_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_pll_rst_seq;

  localparam int P_PLL = 4;
  localparam int P_TMO = 32;
  localparam int P_STB = 8;
  localparam int P_SYN = 2;
  localparam int CW    = 4;
  localparam int RW    = 5 + 2 * CW;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct {
    logic [RW-1:0] val;
    int            cyc;
  } exp_t;

  logic          refclk = 1'b0;
  logic          rst = 1'b0;
  logic          locked = 1'b0;
  logic          sw_reset = 1'b0;
  logic          pll_rst, sys_rst, ready;
  logic [CW-1:0] loss_count, timeout_count;
  logic [1:0]    state_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  exp_t exp_q[$];
  logic [RW-1:0] last_obs;
  logic [RW-1:0] last_exp;

  // Reference model: phase number, cycles spent in phase, raw-locked history.
  int m_phase, m_dwell, m_loss, m_tmo;
  bit m_hist[P_SYN];

  debug_pll_rst_seq #(
    .PLL_RST_CYCLES(P_PLL), .LOCK_TIMEOUT(P_TMO), .STABLE_CYCLES(P_STB),
    .SYNC_STAGES(P_SYN), .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .sw_reset(sw_reset),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready),
    .loss_count(loss_count), .timeout_count(timeout_count), .state_o(state_o)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc++;

  function automatic logic [RW-1:0] model_rec();
    return {2'(m_phase), m_phase == 0, m_phase != 3, m_phase == 3,
            CW'(m_loss), CW'(m_tmo)};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_if_changed(input int stamp);
    logic [RW-1:0] r;
    r = model_rec();
    if (r != last_exp) begin
      exp_q.push_back('{val: r, cyc: stamp});
      last_exp = r;
    end
  endtask

  task automatic model_reset(input int stamp);
    m_phase = 0; m_dwell = 0; m_loss = 0; m_tmo = 0;
    for (int i = 0; i < P_SYN; i++) m_hist[i] = 1'b0;
    push_if_changed(stamp);
  endtask

  // Predict the effect of the coming clock edge given the current inputs.
  task automatic model_step();
    bit ls;
    int nxt, done;
    ls   = m_hist[P_SYN-1];
    for (int i = P_SYN - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = locked;
    done = m_dwell + 1;  // cycles completed in the phase after this edge
    nxt  = m_phase;
    if (sw_reset) begin
      if (m_phase == 3 && !ls) m_loss = (m_loss < CMAX) ? m_loss + 1 : CMAX;
      nxt = 0;
    end else if (m_phase == 0) begin
      if (done == P_PLL) nxt = 1;
    end else if (m_phase == 1) begin
      if (ls) nxt = 2;
      else if (done == P_TMO) begin
        nxt = 0;
        m_tmo = (m_tmo < CMAX) ? m_tmo + 1 : CMAX;
      end
    end else if (m_phase == 2) begin
      if (!ls) nxt = 1;
      else if (done == P_STB) nxt = 3;
    end else if (!ls) begin
      m_loss = (m_loss < CMAX) ? m_loss + 1 : CMAX;
`ifdef DEBUG_PLL_RST_SEQ_RELOCK_EN
      nxt = 0;
`else
      nxt = 1;
`endif
    end
    m_dwell = (nxt != m_phase || sw_reset) ? 0 : done;
    m_phase = nxt;
    push_if_changed(cyc + 1);
  endtask

  task automatic tick();
    if (rst) model_reset(cyc + 1);
    else     model_step();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_state(input string name, input int s, input int budget);
    for (int i = 0; i < budget && state_o != 2'(s); i++) tick();
    check(name, int'(state_o), s);
  endtask

  // Measure cycles from the current point until sys_rst reaches a level.
  task automatic latency(input string name, input logic lvl, input int req);
    int c0;
    c0 = cyc;
    for (int i = 0; i < 60 && sys_rst != lvl; i++) tick();
    check(name, cyc - c0, req);
  endtask

  // Scoreboard monitor: every observed output change must match the queue.
  always @(negedge refclk) begin
    logic [RW-1:0] obs;
    exp_t e;
    if (mon_en) begin
      obs = {state_o, pll_rst, sys_rst, ready, loss_count, timeout_count};
      if (obs !== last_obs) begin
        last_obs = obs;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h at cycle %0d, expected no change", obs, cyc);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e.val || cyc != e.cyc) begin
            errors++;
            $display("FAIL sb_event: got %h at cycle %0d, expected %h at cycle %0d",
                     obs, cyc, e.val, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    logic [RW-1:0] rst_rec;
    rst_rec = {2'd0, 1'b1, 1'b1, 1'b0, CW'(0), CW'(0)};
    #1 rst = 1'b1;
    @(posedge refclk); #1;
    check("reset_state", int'({state_o, pll_rst, sys_rst, ready, loss_count, timeout_count}),
          int'(rst_rec));
    m_phase = 0; m_dwell = 0; m_loss = 0; m_tmo = 0;
    for (int i = 0; i < P_SYN; i++) m_hist[i] = 1'b0;
    last_exp = rst_rec;
    last_obs = rst_rec;
    mon_en   = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Bring-up: lock arrives 10 cycles after reset release.
    repeat (10) tick();
    locked = 1'b1;
    latency("bringup_latency", 1'b0, P_SYN + P_STB + 1);
    check("bringup_ready", int'(ready), 1);
    check("bringup_loss", int'(loss_count), 0);
    check("bringup_tmo", int'(timeout_count), 0);

    // Glitch in STABLE: restart, then drop lock for 3 cycles at STABLE cycle 5.
    sw_reset = 1'b1; tick(); sw_reset = 1'b0;
    wait_state("reach_stable", 2, 40);
    repeat (4) tick();
    locked = 1'b0;
    repeat (3) tick();
    check("glitch_state", int'(state_o), 1);
    check("glitch_sysrst", int'(sys_rst), 1);
    locked = 1'b1;
    latency("glitch_relock", 1'b0, P_SYN + P_STB + 1);
    check("glitch_loss", int'(loss_count), 0);

    // Lock loss in RUN.
    locked = 1'b0;
    latency("loss_latency", 1'b1, P_SYN + 1);
    check("loss_count1", int'(loss_count), 1);
`ifdef DEBUG_PLL_RST_SEQ_RELOCK_EN
    check("loss_state", int'(state_o), 0);
`else
    check("loss_state", int'(state_o), 1);
`endif
    locked = 1'b1;
    wait_state("loss_recover", 3, 80);

    // sw_reset coincides with the first cycle lock_s is low in RUN.
    locked = 1'b0;
    repeat (P_SYN) tick();
    sw_reset = 1'b1; tick(); sw_reset = 1'b0;
    check("simul_state", int'(state_o), 0);
    check("simul_loss", int'(loss_count), 2);

    // Lock never arrives: 20 timeouts, counter saturates.
    repeat (20 * (P_PLL + P_TMO) + 4) tick();
    check("tmo_saturate", int'(timeout_count), CMAX);

    // Randomised lock behaviour with occasional software restarts.
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      locked = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        sw_reset = ($urandom_range(0, 15) == 0);
        tick();
      end
      sw_reset = 1'b0;
    end

    // Asynchronous reset during STABLE.
    locked = 1'b1;
    sw_reset = 1'b1; tick(); sw_reset = 1'b0;
    wait_state("reach_stable2", 2, 40);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("async_reset", int'({state_o, pll_rst, sys_rst, ready, loss_count, timeout_count}),
          int'(rst_rec));
    model_reset(cyc);
    tick(); tick();
    rst = 1'b0;
    repeat (20) tick();

    @(negedge refclk); #1;
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
